// File: rtl/mux_8to1_arbiter.sv
// Round-robin arbiter driving the select of a shared mux_8to1 datapath.
// One owner at a time; a hold limit forces handover when others are waiting.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no owner, gnt = 0, sel keeps the last owner
// S_GRANT | owner index held in sel, gnt = 1 << sel
module mux_8to1_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [2:0] last_q, last_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic       owner_req;
  logic       others_req;
  logic       take;

  // Search last+1 .. last+8; the previous owner sits last, so it only wins alone.
  always_comb begin
    logic [2:0] idx;
    win_found = 1'b0;
    win_idx   = last_q;
    idx       = last_q;
    for (int i = 1; i <= 8; i++) begin
      idx = last_q + 3'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign owner_req  = req[sel_q];
  assign others_req = |(req & ~(8'b1 << sel_q));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    take    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) take = 1'b1;
      end
      S_GRANT: begin
        if (!owner_req) begin
          if (win_found) begin
            take = 1'b1;
          end else begin
            state_d = S_IDLE;
            gnt_d   = 8'b0;
            valid_d = 1'b0;
            cnt_d   = 8'd0;
          end
        end else if (others_req && (cnt_q == MAX_HOLD_C)) begin
          take = 1'b1;
        end else if (cnt_q < MAX_HOLD_C) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take) begin
      state_d = S_GRANT;
      sel_d   = win_idx;
      last_d  = win_idx;
      gnt_d   = 8'b1 << win_idx;
      valid_d = 1'b1;
      cnt_d   = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 3'd7;
      sel_q   <= 3'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_8to1_arbiter.sv
// Bench for mux_8to1_arbiter: two instances (hold limit 4 and 1) share stimulus
// and are checked every cycle against a rule-level model, plus directed scenarios.
module tb_mux_8to1_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt4, gnt1;
  logic [2:0] sel4, sel1;
  logic       valid4, valid1;

  int errors = 0;
  int checks = 0;

  mux_8to1_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt4), .sel(sel4), .valid(valid4)
  );
  mux_8to1_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt1), .sel(sel1), .valid(valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state per instance: index 0 -> hold limit 4, index 1 -> hold limit 1.
  bit m_busy [2];
  int m_owner[2];
  int m_last [2];
  int m_cnt  [2];

  function automatic int hold_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int rr_pick(int last, logic [7:0] r);
    for (int off = 1; off <= 8; off++) begin
      int idx;
      idx = (last + off) % 8;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int count_others(int owner, logic [7:0] r);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (i != owner && r[i]) n++;
    return n;
  endfunction

  task automatic model_reset(int k);
    m_busy[k]  = 1'b0;
    m_owner[k] = 0;
    m_last[k]  = 7;
    m_cnt[k]   = 0;
  endtask

  task automatic model_grant(int k, int w);
    m_busy[k]  = 1'b1;
    m_owner[k] = w;
    m_last[k]  = w;
    m_cnt[k]   = 1;
  endtask

  task automatic model_edge(int k, logic rst, logic [7:0] r);
    int w;
    w = rr_pick(m_last[k], r);
    if (rst) begin
      model_reset(k);
    end else if (!m_busy[k]) begin
      if (w >= 0) model_grant(k, w);
    end else if (!r[m_owner[k]]) begin
      if (w >= 0) model_grant(k, w);
      else begin
        m_busy[k] = 1'b0;
        m_cnt[k]  = 0;
      end
    end else if (count_others(m_owner[k], r) > 0 && m_cnt[k] == hold_of(k)) begin
      model_grant(k, w);
    end else if (m_cnt[k] < hold_of(k)) begin
      m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int k, string tag, logic [7:0] g, logic [2:0] s, logic v);
    logic [7:0] eg;
    eg = m_busy[k] ? (8'd1 << m_owner[k]) : 8'd0;
    chk({tag, "_gnt"}, 32'(g), 32'(eg));
    chk({tag, "_sel"}, 32'(s), 32'(m_owner[k]));
    chk({tag, "_valid"}, 32'(v), 32'(m_busy[k]));
  endtask

  // One clock: model follows the same edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge(0, reset, req);
    model_edge(1, reset, req);
    #1;
    check_dut(0, "d4", gnt4, sel4, valid4);
    check_dut(1, "d1", gnt1, sel1, valid1);
    if (m_busy[0]) chk("d4_cnt", 32'(dut4.cnt_q), 32'(m_cnt[0]));
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    req   = 8'h00;
    model_reset(0);
    model_reset(1);

    // Reset then single request
    do_reset(2);
    chk("rst_gnt", 32'(gnt4), 32'h00);
    chk("rst_sel", 32'(sel4), 32'd0);
    chk("rst_valid", 32'(valid4), 32'd0);
    req = 8'b0000_0100;
    step();
    chk("single_gnt", 32'(gnt4), 32'h04);
    chk("single_sel", 32'(sel4), 32'd2);
    req = 8'h00;
    step();
    chk("release_gnt", 32'(gnt4), 32'h00);
    chk("release_valid", 32'(valid4), 32'd0);
    chk("release_sel", 32'(sel4), 32'd2);

    // Round-robin order on the hold-limit-1 instance
    do_reset(1);
    req = 8'hFF;
    for (int i = 0; i <= 8; i++) begin
      step();
      chk("rr_sel", 32'(sel1), 32'(i % 8));
      chk("rr_gnt", 32'(gnt1), 32'(8'd1 << (i % 8)));
    end

    // Hold limit 4: requester 3 keeps the mux 4 cycles, then 5 takes over
    do_reset(1);
    req = 8'b0000_1000;
    step();
    chk("hold_first", 32'(gnt4), 32'h08);
    req = 8'b0010_1000;
    n = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (gnt4[3]) n++;
      else break;
    end
    chk("hold_cycles", 32'(n), 32'd4);
    chk("hold_handover", 32'(gnt4), 32'h20);

    // Solo owner is never preempted
    do_reset(1);
    req = 8'b1000_0000;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("solo_gnt", 32'(gnt4[7]), 32'd1);
    end
    chk("solo_cnt_sat", 32'(dut4.cnt_q), 32'd4);

    // Wrap-around and release handover
    do_reset(1);
    req = 8'b0100_0000;
    step();
    chk("wrap_owner", 32'(sel4), 32'd6);
    req = 8'b0100_0011;
    step();
    chk("wrap_keep", 32'(gnt4), 32'h40);
    req = 8'b0000_0011;
    step();
    chk("wrap_gnt", 32'(gnt4), 32'h01);
    chk("wrap_sel", 32'(sel4), 32'd0);

    // Reset mid-grant
    do_reset(1);
    req = 8'b0001_0000;
    step();
    chk("mid_owner", 32'(gnt4), 32'h10);
    do_reset(1);
    chk("mid_rst_gnt", 32'(gnt4), 32'h00);
    chk("mid_rst_sel", 32'(sel4), 32'd0);
    req = 8'b0001_0001;
    step();
    chk("mid_after_gnt", 32'(gnt4), 32'h01);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: req = 8'($urandom);
        1: req = 8'($urandom) & 8'($urandom);
        2: req = 8'd1 << $urandom_range(0, 7);
        default: req = req;
      endcase
      reset = ($urandom_range(0, 60) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_8to1_arbiter.md
# mux_8to1_arbiter

Round-robin arbiter that shares one `mux_8to1` datapath between eight requesters. It accepts a request vector, grants exactly one requester at a time, and drives the mux select with the granted index. A hold limit prevents a requester from keeping the mux while others wait. It sits directly in front of the `sel` input of a `mux_8to1` instance.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while another requester is waiting; legal range 1..255.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  8  request vector; bit i is requester i, level-sensitive.
- `gnt`  out  8  one-hot grant vector, or all-zero when idle; registered.
- `sel`  out  3  binary index of the current or last owner; drives the `mux_8to1` select; registered.
- `valid`  out  1  high while `gnt` is non-zero; registered; equals `|gnt`.

## Operation
- State machine with two states:
  - IDLE: no owner.
  - GRANT: owner index held in `sel`.
- Priority pointer `last` holds the index of the most recent owner.
  - Search order is `last+1`, `last+2`, … modulo 8, wrapping 7→0.
  - The first index in that order with `req` high wins.
  - The old owner can only win if no other bit is set.
- Hold counter `cnt` (8 bits):
  - Set to 1 on every new grant.
  - Increments each cycle the same owner is retained.
  - Saturates at `MAX_HOLD`.
- IDLE transitions:
  - `req` == 0: stay in IDLE.
  - `req` != 0: go to GRANT. Owner = search winner; `sel` = owner; `gnt` = 1<<owner; `last` = owner; `cnt` = 1.
- GRANT, owner's `req` bit low:
  - Other requests pending: grant the search winner from `last+1`, with no idle cycle between owners.
  - No requests pending: go to IDLE. `gnt` = 0, `valid` = 0, `sel` keeps the old owner.
- GRANT, owner's `req` bit high:
  - Another `req` bit high and `cnt` == `MAX_HOLD`: preempt. Grant the search winner from `last+1`; `cnt` = 1.
  - Otherwise: keep the owner, advance `cnt` (saturating).
- Simultaneous events:
  - If the owner drops and new requests arrive on the same edge, the drop rule applies.
  - Requests arriving during a grant never change `sel` mid-grant.
- `gnt` is always one-hot or zero. `gnt[sel]` == `valid`.
- Reset:
  - Values: state IDLE, `gnt` = 0, `valid` = 0, `sel` = 3'b000, `last` = 3'd7 (so index 0 has highest priority first), `cnt` = 0.
  - Reset has priority over every event, including mid-grant: the grant is dropped on that edge.

## Timing
- Request-to-grant latency is 1 cycle. `req[i]` sampled high at edge N gives `gnt[i]` high after edge N.
- Release latency is 1 cycle. The owner's `req` sampled low at edge N gives `gnt` updated after edge N.
- Handover has no bubble. The next owner's `gnt` rises on the same edge the previous owner's falls.
- Preemption occurs after exactly `MAX_HOLD` grant cycles, counting from the first cycle `gnt` is high, when a contender is present.
  - With `MAX_HOLD` = 1 and continuous contention, ownership rotates every cycle.
- `sel` changes only on an edge that issues a new grant. A downstream `mux_8to1.out` is valid combinationally in the same cycle as `gnt`.
- Requesters must not treat `req` as accepted until they see their `gnt` bit high.

## Test plan
- Reset then single request:
  - Assert `reset` for 2 cycles, then `req` = 8'b0000_0100.
  - Required: `gnt` = 8'b0000_0100 and `sel` = 2 one cycle later.
  - Drop `req`: `gnt` = 0, `valid` = 0, `sel` stays 2.
- Round-robin order:
  - From reset, hold `req` = 8'hFF with `MAX_HOLD` = 1.
  - Required: `sel` sequence 0,1,2,…,7,0 on consecutive cycles, one-hot `gnt` every cycle.
- Hold limit:
  - `MAX_HOLD` = 4; requester 3 granted, `req[5]` rises while `req[3]` stays high.
  - Required: `gnt[3]` high for exactly 4 cycles total, then `gnt` = 8'b0010_0000 with no gap.
- Solo owner is not preempted:
  - `req` = 8'b1000_0000 held for 20 cycles.
  - Required: `gnt[7]` high continuously, `cnt` saturates at `MAX_HOLD`.
- Wrap-around and release handover:
  - Owner 6, `req` = 8'b0100_0011, then `req[6]` drops.
  - Required: next cycle `gnt` = 8'b0000_0001, `sel` = 0.
- Reset mid-grant:
  - Assert `reset` while `gnt[4]` is high.
  - Required: next cycle `gnt` = 0, `sel` = 0.
  - Release reset with `req` = 8'b0001_0001: index 0 is granted first.
